// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with a sign fix-up cycle and early-out divide corner cases.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_f3;
  logic [5:0]        r_count;
  logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_prod;     // upper half accumulates, lower half holds the multiplier
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;      // dividend shifts out as quotient bits shift in
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  logic [XLEN:0]     w_add;
  logic [XLEN+1:0]   w_shift;
  logic [XLEN+1:0]   w_trial;
  logic              w_fits;

  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  // Operand decode, valid while idle
  assign w_accept   = (r_state == S_IDLE) & start & ~flush;
  assign w_a_signed = (funct3 == F_MULH) | (funct3 == F_MULHSU) |
                      (funct3 == F_DIV)  | (funct3 == F_REM);
  assign w_b_signed = (funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM);
  assign w_a_neg    = w_a_signed & a[XLEN-1];
  assign w_b_neg    = w_b_signed & b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -a : a;
  assign w_abs_b    = w_b_neg ? -b : b;

  assign w_div_zero = funct3[2] & (b == '0);
  assign w_div_ovf  = ((funct3 == F_DIV) | (funct3 == F_REM)) &
                      (a == MOST_NEG) & (b == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  assign w_special_res = w_div_zero ? (funct3[1] ? a : '1)
                                    : (funct3[1] ? '0 : MOST_NEG);

  // One radix-2 step of each algorithm
  assign w_add   = r_prod[0] ? ({1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_opnd})
                             : {1'b0, r_prod[2*XLEN-1:XLEN]};
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {2'b00, r_opnd};
  assign w_fits  = ~w_trial[XLEN+1];

  assign w_prod_fix = r_neg_res ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_res ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_rem ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_fix_res = w_prod_fix[XLEN-1:0];
    case (r_f3)
      F_MUL:                      w_fix_res = w_prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              w_fix_res = w_quo_fix;
      F_REM, F_REMU:              w_fix_res = w_rem_fix;
      default:                    w_fix_res = w_prod_fix[XLEN-1:0];
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_count == LAST_STEP) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
    stall = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
  end

  // NOTE: datapath registers are reset as well, so an aborted operation leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f3      <= '0;
      r_count   <= '0;
      r_opnd    <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_f3      <= funct3;
      r_count   <= '0;
      r_opnd    <= funct3[2] ? w_abs_b : w_abs_a;
      r_prod    <= {{XLEN{1'b0}}, w_abs_b};
      r_rem     <= '0;
      r_quo     <= w_abs_a;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      if (w_special) r_result <= w_special_res;
    end else if (!flush && r_state == S_CALC) begin
      r_count <= r_count + 6'd1;
      if (r_f3[2]) begin
        r_rem <= w_fits ? w_trial[XLEN:0] : w_shift[XLEN:0];
        r_quo <= {r_quo[XLEN-2:0], w_fits};
      end else begin
        r_prod <= {w_add, r_prod[XLEN-1:1]};
      end
    end else if (!flush && r_state == S_FIX) begin
      r_result <= w_fix_res;
    end
  end

  assign result = r_result;

endmodule
